gerenciador_atributos: RTL



---
 rtl/gerenciador_atributos_if.sv | 33 +++
 rtl/gerenciador_atributos.sv | 97 +++++++++
 2 files changed

// File: rtl/gerenciador_atributos_if.sv
// Bus between the state controller and the attribute manager.
// TAMAGOTCHI_PASSO_DEBUG_EN adds the passo single-step signal.
interface gerenciador_atributos_if;
    logic [3:0] estado;
    logic [7:0] fome;
    logic [7:0] felicidade;
    logic [7:0] sono;
    logic       tick;
    logic [2:0] alerta;
`ifdef TAMAGOTCHI_PASSO_DEBUG_EN
    logic       passo;

    modport master (
        output estado, passo,
        input  fome, felicidade, sono, tick, alerta
    );

    modport slave (
        input  estado, passo,
        output fome, felicidade, sono, tick, alerta
    );
`else
    modport master (
        output estado,
        input  fome, felicidade, sono, tick, alerta
    );

    modport slave (
        input  estado,
        output fome, felicidade, sono, tick, alerta
    );
`endif
endinterface

// File: rtl/gerenciador_atributos.sv
// Pet need attributes (fome, felicidade, sono) updated with saturating steps on a prescaler tick.
// Optional macro TAMAGOTCHI_PASSO_DEBUG_EN: passo forces an immediate update and restarts the prescaler.
module gerenciador_atributos #(
    parameter int unsigned TICK_CYCLES   = 65536,
    parameter logic [7:0]  INIT          = 8'd200,
    parameter logic [7:0]  DECAY         = 8'd1,
    parameter logic [7:0]  GANHO         = 8'd5,
    parameter logic [7:0]  LIMIAR_ALERTA = 8'd32
) (
    input logic                   clk,
    input logic                   rst,
    gerenciador_atributos_if.slave bus
);
    localparam int unsigned   CW     = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] ULTIMO = CW'(TICK_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'b0000,
        DORMINDO   = 4'b0001,
        COMENDO    = 4'b0010,
        DANDO_AULA = 4'b0100,
        MORTO      = 4'b1000
    } estado_t;

    logic [CW-1:0] cnt;
    logic [7:0]    fome_q, felicidade_q, sono_q;
    logic [7:0]    fome_n, felicidade_n, sono_n;
    logic          tick_q;
    logic          atualiza;
    estado_t       est;

    // 9-bit arithmetic: bit 8 flags borrow/carry so results clamp instead of wrapping
    function automatic logic [7:0] sat_sub(input logic [7:0] v);
        logic [8:0] d;
        d = {1'b0, v} - {1'b0, DECAY};
        return d[8] ? '0 : d[7:0];
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} + {1'b0, GANHO};
        return s[8] ? '1 : s[7:0];
    endfunction

    assign est = estado_t'(bus.estado);

`ifdef TAMAGOTCHI_PASSO_DEBUG_EN
    assign atualiza = bus.passo || (cnt == ULTIMO);
`else
    assign atualiza = (cnt == ULTIMO);
`endif

    always_comb begin
        fome_n       = sat_sub(fome_q);
        felicidade_n = sat_sub(felicidade_q);
        sono_n       = sat_sub(sono_q);
        case (est)
            COMENDO:    fome_n       = sat_add(fome_q);
            DORMINDO:   sono_n       = sat_add(sono_q);
            DANDO_AULA: felicidade_n = sat_add(felicidade_q);
            MORTO: begin
                fome_n       = fome_q;
                felicidade_n = felicidade_q;
                sono_n       = sono_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            tick_q       <= 1'b0;
            fome_q       <= INIT;
            felicidade_q <= INIT;
            sono_q       <= INIT;
        end else begin
            tick_q <= atualiza;
            if (atualiza) begin
                cnt          <= '0;
                fome_q       <= fome_n;
                felicidade_q <= felicidade_n;
                sono_q       <= sono_n;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.fome       = fome_q;
    assign bus.felicidade = felicidade_q;
    assign bus.sono       = sono_q;
    assign bus.tick       = tick_q;
    assign bus.alerta     = {fome_q <= LIMIAR_ALERTA,
                             felicidade_q <= LIMIAR_ALERTA,
                             sono_q <= LIMIAR_ALERTA};
endmodule
